// File: rtl/stream_mux_rr.sv
// N-to-1 stream multiplexer with a registered output stage, valid/ready on every
// channel, and either fixed-select or round-robin channel selection.
module stream_mux_rr #(
    parameter int N     = 4,
    parameter int W     = 8,
    parameter int SEL_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N*W-1:0]   in_data,
    input  logic [N-1:0]     in_valid,
    output logic [N-1:0]     in_ready,
    input  logic             mode,
    input  logic [SEL_W-1:0] sel,
    output logic [W-1:0]     out_data,
    output logic [SEL_W-1:0] out_chan,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [SEL_W-1:0] ptr;
    logic             accept;
    logic             grant_valid;
    logic [SEL_W-1:0] grant_idx;
    logic [W-1:0]     grant_data;
    logic             xfer;
    int unsigned      scan_idx;

    assign accept = !out_valid || out_ready;
    assign xfer   = accept && grant_valid;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        scan_idx    = 0;
        if (!mode) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (sel == SEL_W'(i) && in_valid[i]) begin
                    grant_valid = 1'b1;
                    grant_idx   = SEL_W'(i);
                end
            end
        end else begin
            // Scan starts at ptr and wraps at N, not at 2**SEL_W.
            for (int unsigned k = 0; k < N; k++) begin
                scan_idx = int'(ptr) + k;
                if (scan_idx >= N) scan_idx = scan_idx - N;
                if (!grant_valid && in_valid[scan_idx]) begin
                    grant_valid = 1'b1;
                    grant_idx   = SEL_W'(scan_idx);
                end
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant_idx == SEL_W'(i)) grant_data = in_data[i*W +: W];
        end
    end

    always_comb begin
        in_ready = '0;
        if (rst_n && xfer) in_ready = N'(1) << grant_idx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            ptr       <= '0;
        end else begin
            if (xfer) begin
                out_data  <= grant_data;
                out_chan  <= grant_idx;
                out_valid <= 1'b1;
                if (mode) ptr <= (grant_idx == SEL_W'(N-1)) ? '0 : grant_idx + SEL_W'(1);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: a 4-channel vector table plus hand sequences
// for a 3-channel build and asynchronous reset mid-stream.
module tb_stream_mux_rr;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // N=4 instance
    logic [31:0] d4_data;
    logic [3:0]  d4_valid, d4_ready;
    logic        d4_mode, d4_ovalid, d4_oready;
    logic [1:0]  d4_sel, d4_chan;
    logic [7:0]  d4_odata;

    // N=3 instance
    logic [23:0] d3_data;
    logic [2:0]  d3_valid, d3_ready;
    logic        d3_mode, d3_ovalid, d3_oready;
    logic [1:0]  d3_sel, d3_chan;
    logic [7:0]  d3_odata;

    stream_mux_rr #(.N(4), .W(8), .SEL_W(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_data(d4_data), .in_valid(d4_valid),
        .in_ready(d4_ready), .mode(d4_mode), .sel(d4_sel), .out_data(d4_odata),
        .out_chan(d4_chan), .out_valid(d4_ovalid), .out_ready(d4_oready)
    );

    stream_mux_rr #(.N(3), .W(8), .SEL_W(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_data(d3_data), .in_valid(d3_valid),
        .in_ready(d3_ready), .mode(d3_mode), .sel(d3_sel), .out_data(d3_odata),
        .out_chan(d3_chan), .out_valid(d3_ovalid), .out_ready(d3_oready)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       mode;
        logic [1:0] sel;
        logic [3:0] iv;
        logic       ordy;
        logic [3:0] exp_rdy;
        logic       exp_ov;
        logic [7:0] exp_d;
        logic [1:0] exp_ch;
    } vec_t;

    vec_t vecs[25];

    initial begin
        // fixed select, sel=2 then sel=3
        vecs[0]  = '{1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'h30, 2'd2};
        vecs[1]  = '{1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'h30, 2'd2};
        vecs[2]  = '{1'b0, 2'd3, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'h40, 2'd3};
        // round-robin, all valid
        vecs[3]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
        vecs[4]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'h20, 2'd1};
        vecs[5]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'h30, 2'd2};
        vecs[6]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'h40, 2'd3};
        vecs[7]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
        // round-robin, sparse valid 1010 then 0001
        vecs[8]  = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 8'h20, 2'd1};
        vecs[9]  = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 8'h40, 2'd3};
        vecs[10] = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 8'h20, 2'd1};
        vecs[11] = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 8'h40, 2'd3};
        vecs[12] = '{1'b1, 2'd0, 4'b0001, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
        // back-pressure: word 0x20/ch1 held for 5 cycles
        vecs[13] = '{1'b1, 2'd0, 4'b0010, 1'b1, 4'b0010, 1'b1, 8'h20, 2'd1};
        vecs[14] = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'h20, 2'd1};
        vecs[15] = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'h20, 2'd1};
        vecs[16] = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'h20, 2'd1};
        vecs[17] = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'h20, 2'd1};
        vecs[18] = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'h20, 2'd1};
        vecs[19] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'h30, 2'd2};
        // drain, then fixed select of an idle channel while others are valid
        vecs[20] = '{1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h30, 2'd2};
        vecs[21] = '{1'b0, 2'd1, 4'b1101, 1'b1, 4'b0000, 1'b0, 8'h30, 2'd2};
        vecs[22] = '{1'b0, 2'd1, 4'b0010, 1'b0, 4'b0010, 1'b1, 8'h20, 2'd1};
        vecs[23] = '{1'b0, 2'd1, 4'b0010, 1'b0, 4'b0000, 1'b1, 8'h20, 2'd1};
        // back to round-robin: pointer was left at 3 by the last rr transfer
        vecs[24] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'h40, 2'd3};
    end

    initial begin
        logic [2:0] r3_exp[4];
        logic [1:0] c3_exp[4];
        logic [7:0] d3_exp[4];
        r3_exp[0] = 3'b001; r3_exp[1] = 3'b010; r3_exp[2] = 3'b100; r3_exp[3] = 3'b001;
        c3_exp[0] = 2'd0;   c3_exp[1] = 2'd1;   c3_exp[2] = 2'd2;   c3_exp[3] = 2'd0;
        d3_exp[0] = 8'h10;  d3_exp[1] = 8'h20;  d3_exp[2] = 8'h30;  d3_exp[3] = 8'h10;

        rst_n     = 1'b0;
        d4_data   = {8'h40, 8'h30, 8'h20, 8'h10};
        d4_valid  = 4'b1111;
        d4_mode   = 1'b1;
        d4_sel    = 2'd0;
        d4_oready = 1'b1;
        d3_data   = {8'h30, 8'h20, 8'h10};
        d3_valid  = 3'b000;
        d3_mode   = 1'b1;
        d3_sel    = 2'd0;
        d3_oready = 1'b1;

        #12;
        chk("rst_ovalid", 32'(d4_ovalid), 32'd0);
        chk("rst_odata",  32'(d4_odata),  32'd0);
        chk("rst_ochan",  32'(d4_chan),   32'd0);
        chk("rst_iready", 32'(d4_ready),  32'd0);

        d4_valid = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            d4_mode   = vecs[i].mode;
            d4_sel    = vecs[i].sel;
            d4_valid  = vecs[i].iv;
            d4_oready = vecs[i].ordy;
            #1;
            chk($sformatf("v%0d_iready", i), 32'(d4_ready), 32'(vecs[i].exp_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_ovalid", i), 32'(d4_ovalid), 32'(vecs[i].exp_ov));
            chk($sformatf("v%0d_odata", i),  32'(d4_odata),  32'(vecs[i].exp_d));
            chk($sformatf("v%0d_ochan", i),  32'(d4_chan),   32'(vecs[i].exp_ch));
        end

        // N=3: round-robin wraps 2 -> 0, never producing index 3
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            d3_mode  = 1'b1;
            d3_valid = 3'b111;
            #1;
            chk($sformatf("n3_rr%0d_iready", i), 32'(d3_ready), 32'(r3_exp[i]));
            @(posedge clk);
            #1;
            chk($sformatf("n3_rr%0d_ovalid", i), 32'(d3_ovalid), 32'd1);
            chk($sformatf("n3_rr%0d_ochan", i),  32'(d3_chan),   32'(c3_exp[i]));
            chk($sformatf("n3_rr%0d_odata", i),  32'(d3_odata),  32'(d3_exp[i]));
        end
        // N=3: fixed select of a non-existent channel grants nothing and drains
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            d3_mode = 1'b0;
            d3_sel  = 2'd3;
            #1;
            chk($sformatf("n3_sel3_%0d_iready", i), 32'(d3_ready), 32'd0);
            @(posedge clk);
            #1;
            chk($sformatf("n3_sel3_%0d_ovalid", i), 32'(d3_ovalid), 32'd0);
        end

        // Asynchronous reset mid-stream while out_valid is high
        @(negedge clk);
        d4_mode   = 1'b1;
        d4_valid  = 4'b1111;
        d4_oready = 1'b1;
        #1;
        chk("pre_arst_ovalid", 32'(d4_ovalid), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_ovalid", 32'(d4_ovalid), 32'd0);
        chk("arst_odata",  32'(d4_odata),  32'd0);
        chk("arst_ochan",  32'(d4_chan),   32'd0);
        chk("arst_iready", 32'(d4_ready),  32'd0);
        chk("arst_n3_ovalid", 32'(d3_ovalid), 32'd0);
        @(posedge clk);
        #1;
        chk("arst_hold_ovalid", 32'(d4_ovalid), 32'd0);
        chk("arst_hold_iready", 32'(d4_ready),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_iready", 32'(d4_ready), 32'b0001);
        @(posedge clk);
        #1;
        chk("post_rst_ovalid", 32'(d4_ovalid), 32'd1);
        chk("post_rst_ochan",  32'(d4_chan),   32'd0);
        chk("post_rst_odata",  32'(d4_odata),  32'h10);
        @(negedge clk);
        #1;
        chk("post_rst_next_iready", 32'(d4_ready), 32'b0010);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised N-to-1 stream multiplexer with a registered output and a valid/ready handshake on every channel.
- Successor to the combinational 4x1 mux. Adds configurable channel count and width, back-pressure, a registered output with channel tag, and two selection modes: fixed select and round-robin arbitration.
- Used wherever several producers share one downstream consumer.

Parameters:
- N, 4, number of input channels (>=2; non-power-of-2 allowed).
- W, 8, data width per channel in bits.
- SEL_W, 2, select/tag width; must equal ceil(log2(N)).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  N*W  channel i data at bits [i*W +: W].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready; at most one bit high per cycle.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SEL_W  channel index used in fixed mode.
- out_data  output  W  registered output data.
- out_chan  output  SEL_W  index of the channel that supplied out_data.
- out_valid  output  1  output holds an unconsumed word.
- out_ready  input  1  downstream accepts when high with out_valid.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, out_data=0, out_chan=0, round-robin pointer ptr=0.
  - in_ready forced all-zero while rst_n is low.
- Load enable: accept = !out_valid || out_ready, giving full throughput of one word per cycle.
- Grant (combinational, evaluated each cycle):
  - Fixed mode: grant = sel if sel < N and in_valid[sel]; otherwise no grant. Other channels are never granted, even if valid.
  - Round-robin mode: grant = first i with in_valid[i] high, scanning ptr, ptr+1, ... wrapping modulo N (not modulo 2^SEL_W). No grant if no channel is valid.
- in_ready[g] = accept && grant exists; every other in_ready bit is 0. Transfer on channel g occurs when in_valid[g] && in_ready[g].
- On transfer:
  - out_data <= channel g data, out_chan <= g, out_valid <= 1.
  - Latency: one cycle from input transfer to out_valid.
- If out_valid && out_ready and there is no new transfer, out_valid <= 0. out_data and out_chan hold their last values.
- If out_valid && !out_ready, the output register holds (data, chan and valid stable) and all in_ready bits are 0.
- Pointer update:
  - After a round-robin transfer from g: ptr <= (g == N-1) ? 0 : g+1.
  - In fixed mode ptr is unchanged.
  - ptr never takes a value >= N.
- Mode or sel may change on any cycle. The change affects only the next grant; a word already held in the output register is unaffected.
- Input stability: an input may drop in_valid before being granted. The block imposes no stability requirement and introduces no glitch.
- Simultaneous pop and push (out_valid && out_ready with a new transfer): the new word replaces the old one in the same edge, and out_valid stays 1.
- Reset asserted mid-transfer: all state clears immediately. A word in flight is lost, and no in_ready is high during reset.
- Reset deassertion: the first grant is possible on the first clock edge after rst_n rises.

Test Plan:
- Fixed mode, N=4, W=8, sel=2, in_valid=4'b1111, data ch0..3 = 0x10,0x20,0x30,0x40, out_ready=1 -> in_ready=4'b0100 every cycle; out_data=0x30, out_chan=2, out_valid=1 from cycle 1 onward. Then sel=3 -> next word is 0x40, chan 3.
- Round-robin, all four channels valid, out_ready=1 -> out_chan sequence 0,1,2,3,0,1... one word per cycle; in_ready one-hot, rotating.
- Round-robin with in_valid=4'b1010 -> out_chan alternates 1,3,1,3; channels 0 and 2 are never granted. Then in_valid=4'b0001 -> chan 0 granted on the next cycle.
- Back-pressure: out_ready=0 after the first word (0x20, chan 1) -> out_valid=1 and out_data=0x20 held for 5 cycles, in_ready=0. On out_ready=1, the next word is accepted that same cycle and appears the following cycle.
- N=3 build, round-robin, all valid -> chan sequence 0,1,2,0 (no index 3). Fixed mode with sel=3 -> in_ready=0, out_valid falls to 0 after drain.
- Assert rst_n low asynchronously mid-stream with out_valid=1 -> out_valid, out_data and out_chan go to 0 without a clock, in_ready=0. After release, round-robin restarts at chan 0.
